// File: rtl/pkt_rx_ctrl.sv
// Receive-side read controller: paces MAC frame reads, buffers the one-cycle read latency in a
// skid FIFO, presents frames on a valid/ready stream and keeps packet/byte/error statistics.
module pkt_rx_ctrl #(
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic        clk_156m25,
  input  logic        reset_156m25_n,
  input  logic        cfg_enable,
  input  logic        pkt_rx_avail,
  output logic        pkt_rx_ren,
  input  logic        pkt_rx_val,
  input  logic [63:0] pkt_rx_data,
  input  logic        pkt_rx_sop,
  input  logic        pkt_rx_eop,
  input  logic [2:0]  pkt_rx_mod,
  input  logic        pkt_rx_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic [2:0]  out_mod,
  output logic        out_err,
  output logic [31:0] rx_pkt_cnt,
  output logic [31:0] rx_byte_cnt,
  output logic [15:0] rx_err_cnt,
  output logic        proto_err
);

  localparam int unsigned PtrW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(SKID_DEPTH);

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  state_e            state_q;
  logic              ren_q;
  logic              in_frame_q;
  logic              proto_err_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [31:0]       pkt_cnt_q, byte_cnt_q;
  logic [15:0]       err_cnt_q;
  logic [63:0]       data_mem [SKID_DEPTH];
  logic [5:0]        ctl_mem  [SKID_DEPTH];  // {sop, eop, mod[2:0], err}

  logic              eop_in, viol, err_in, push, pop, fifo_empty, fifo_full;
  logic [CntW:0]     occupancy;
  logic [5:0]        head_ctl;
  logic [3:0]        byte_inc;

  always_comb begin
    eop_in     = pkt_rx_val && pkt_rx_eop;
    // Words in the FIFO plus the one read still in flight must fit.
    occupancy  = {1'b0, count_q} + {{CntW{1'b0}}, ren_q};
    pkt_rx_ren = reset_156m25_n && (state_q == StRead) && (occupancy < {1'b0, DepthCnt}) &&
                 !eop_in;

    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DepthCnt);
    out_valid  = reset_156m25_n && !fifo_empty;
    pop        = out_valid && out_ready;
    push       = pkt_rx_val && (!fifo_full || pop);

    viol   = pkt_rx_val && (!ren_q || (in_frame_q ? pkt_rx_sop : !pkt_rx_sop));
    err_in = (pkt_rx_err && pkt_rx_eop) || viol;

    head_ctl = ctl_mem[rd_ptr_q];
    out_data = out_valid ? data_mem[rd_ptr_q] : 64'd0;
    out_sop  = out_valid && head_ctl[5];
    out_eop  = out_valid && head_ctl[4];
    out_mod  = out_valid ? head_ctl[3:1] : 3'd0;
    out_err  = out_valid && head_ctl[0];

    byte_inc = (!out_eop || (out_mod == 3'd0)) ? 4'd8 : {1'b0, out_mod};
  end

  always_ff @(posedge clk_156m25) begin
    if (push) begin
      data_mem[wr_ptr_q] <= pkt_rx_data;
      ctl_mem[wr_ptr_q]  <= {pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, err_in};
    end
  end

  always_ff @(posedge clk_156m25) begin
    if (!reset_156m25_n) begin
      state_q     <= StIdle;
      ren_q       <= 1'b0;
      in_frame_q  <= 1'b0;
      proto_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (cfg_enable && pkt_rx_avail) state_q <= StRead;
        StRead: if (eop_in) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      ren_q       <= pkt_rx_ren;
      proto_err_q <= viol;
      if (pkt_rx_val) in_frame_q <= !pkt_rx_eop;

      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase

      if (pop) begin
        byte_cnt_q <= byte_cnt_q + {28'd0, byte_inc};
        if (out_eop) begin
          pkt_cnt_q <= pkt_cnt_q + 32'd1;
          if (out_err && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
        end
      end
    end
  end

  assign rx_pkt_cnt  = pkt_cnt_q;
  assign rx_byte_cnt = byte_cnt_q;
  assign rx_err_cnt  = err_cnt_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_pkt_rx_ctrl.sv
// Bench for pkt_rx_ctrl: behavioural MAC read port feeding a scoreboard of expected words, with
// independent packet/byte/error counter model.
module tb_pkt_rx_ctrl;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
    logic        xerr;
  } word_t;

  logic        clk_156m25 = 1'b0;
  logic        reset_156m25_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic        pkt_rx_avail = 1'b0;
  logic        pkt_rx_ren;
  logic        pkt_rx_val = 1'b0;
  logic [63:0] pkt_rx_data = 64'd0;
  logic        pkt_rx_sop = 1'b0;
  logic        pkt_rx_eop = 1'b0;
  logic [2:0]  pkt_rx_mod = 3'd0;
  logic        pkt_rx_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_sop, out_eop, out_err;
  logic [2:0]  out_mod;
  logic [31:0] rx_pkt_cnt, rx_byte_cnt;
  logic [15:0] rx_err_cnt;
  logic        proto_err;

  pkt_rx_ctrl #(.SKID_DEPTH(4)) dut (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .cfg_enable     (cfg_enable),
    .pkt_rx_avail   (pkt_rx_avail),
    .pkt_rx_ren     (pkt_rx_ren),
    .pkt_rx_val     (pkt_rx_val),
    .pkt_rx_data    (pkt_rx_data),
    .pkt_rx_sop     (pkt_rx_sop),
    .pkt_rx_eop     (pkt_rx_eop),
    .pkt_rx_mod     (pkt_rx_mod),
    .pkt_rx_err     (pkt_rx_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_mod        (out_mod),
    .out_err        (out_err),
    .rx_pkt_cnt     (rx_pkt_cnt),
    .rx_byte_cnt    (rx_byte_cnt),
    .rx_err_cnt     (rx_err_cnt),
    .proto_err      (proto_err)
  );

  always #5 clk_156m25 = ~clk_156m25;

  word_t       mac_q[$];
  word_t       sb[$];
  int          n_checks = 0, n_errors = 0;
  int          ren_cnt = 0, pop_cnt = 0, proto_cnt = 0, ren_after_eop = 0, words_driven = 0;
  logic        ren_seen = 1'b0, inject = 1'b0, avail_hold = 1'b0;
  logic        en_want = 1'b0, ready_want = 1'b0, rst_want = 1'b0;
  logic [31:0] exp_pkt = 32'd0, exp_bytes = 32'd0;
  logic [15:0] exp_err = 16'd0;

  task automatic add_frame(input int n, input logic [2:0] mod, input logic err,
                           input int bad_sop);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.data = {$urandom, $urandom};
      w.sop  = (i == 0) || (i == bad_sop);
      w.eop  = (i == n - 1);
      w.mod  = (i == n - 1) ? mod : 3'd0;
      w.err  = err && (i == n - 1);
      w.xerr = (err && (i == n - 1)) || ((i == bad_sop) && (i != 0));
      mac_q.push_back(w);
    end
  endtask

  // One clock: drive inputs on the falling edge, then observe the settled DUT outputs.
  task automatic step();
    word_t w, e;
    logic  drove_eop;
    @(negedge clk_156m25);
    reset_156m25_n = rst_want;
    cfg_enable     = en_want;
    out_ready      = ready_want;
    pkt_rx_val = 1'b0; pkt_rx_sop = 1'b0; pkt_rx_eop = 1'b0;
    pkt_rx_mod = 3'd0; pkt_rx_err = 1'b0; pkt_rx_data = 64'd0;
    drove_eop = 1'b0;
    if ((ren_seen || inject) && (mac_q.size() > 0)) begin
      w = mac_q.pop_front();
      pkt_rx_val = 1'b1; pkt_rx_data = w.data; pkt_rx_sop = w.sop; pkt_rx_eop = w.eop;
      pkt_rx_mod = w.mod; pkt_rx_err = w.err;
      sb.push_back(w);
      drove_eop = w.eop;
      words_driven++;
    end
    inject = 1'b0;
    pkt_rx_avail = avail_hold || (mac_q.size() > 0);
    #1;
    ren_seen = pkt_rx_ren;
    if (ren_seen) ren_cnt++;
    if (drove_eop && pkt_rx_ren) ren_after_eop++;
    if (proto_err) proto_cnt++;
    if (out_valid && out_ready) begin
      pop_cnt++;
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL out_word unexpected word got data=%h sop=%b eop=%b want none",
                 out_data, out_sop, out_eop);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.data || out_sop !== e.sop || out_eop !== e.eop ||
            out_mod !== e.mod || out_err !== e.xerr) begin
          n_errors++;
          $display("FAIL out_word got %h/%b/%b/%0d/%b want %h/%b/%b/%0d/%b", out_data, out_sop,
                   out_eop, out_mod, out_err, e.data, e.sop, e.eop, e.mod, e.xerr);
        end
        exp_bytes = exp_bytes + ((!e.eop || e.mod == 3'd0) ? 32'd8 : {29'd0, e.mod});
        if (e.eop) begin
          exp_pkt = exp_pkt + 32'd1;
          if (e.xerr && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    int budget = 80;
    while ((mac_q.size() > 0 || sb.size() > 0) && budget > 0) begin
      step();
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_errors++;
      $display("FAIL %s drain timeout got mac=%0d sb=%0d want 0/0", tag, mac_q.size(), sb.size());
    end
    repeat (3) step();
  endtask

  task automatic check_stats(input string tag);
    n_checks++;
    if (rx_pkt_cnt !== exp_pkt || rx_byte_cnt !== exp_bytes || rx_err_cnt !== exp_err) begin
      n_errors++;
      $display("FAIL %s stats got %0d/%h/%h want %0d/%h/%h", tag, rx_pkt_cnt, rx_byte_cnt,
               rx_err_cnt, exp_pkt, exp_bytes, exp_err);
    end
  endtask

  task automatic test_reset();
    rst_want = 1'b0;
    repeat (3) step();
    rst_want = 1'b1;
    step();
    n_checks++;
    if ({pkt_rx_ren, out_valid, out_sop, out_eop, out_err, proto_err} !== 6'd0 ||
        out_data !== 64'd0 || out_mod !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got ren=%b val=%b data=%h want all 0", pkt_rx_ren, out_valid,
               out_data);
    end
    n_checks++;
    if (rx_pkt_cnt !== 32'd0 || rx_byte_cnt !== 32'd0 || rx_err_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_counters got %h/%h/%h want 0", rx_pkt_cnt, rx_byte_cnt, rx_err_cnt);
    end
  endtask

  task automatic test_frame_read();
    int first_ren = -1, first_pop = -1, p0 = pop_cnt;
    ren_cnt = 0; ren_after_eop = 0;
    add_frame(3, 3'd5, 1'b0, -1);
    en_want = 1'b1; ready_want = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ren_seen && first_ren < 0) first_ren = i;
      if (pop_cnt > p0 && first_pop < 0) first_pop = i;
    end
    n_checks++;
    if (first_ren != 1) begin
      n_errors++; $display("FAIL frame_first_ren got %0d want 1", first_ren);
    end
    n_checks++;
    if (first_pop != 3) begin
      n_errors++; $display("FAIL frame_latency got %0d want 3", first_pop);
    end
    n_checks++;
    if (ren_cnt != 3 || ren_after_eop != 0) begin
      n_errors++;
      $display("FAIL frame_ren got %0d/%0d want 3/0", ren_cnt, ren_after_eop);
    end
    n_checks++;
    if (pop_cnt - p0 != 3 || sb.size() != 0) begin
      n_errors++; $display("FAIL frame_words got %0d want 3", pop_cnt - p0);
    end
    n_checks++;
    if (rx_pkt_cnt !== 32'd1 || rx_byte_cnt !== 32'd21) begin
      n_errors++;
      $display("FAIL frame_stats got %0d/%0d want 1/21", rx_pkt_cnt, rx_byte_cnt);
    end
  endtask

  task automatic test_backpressure();
    int d0 = words_driven, p0 = pop_cnt;
    logic [31:0] b0 = rx_byte_cnt;
    add_frame(10, 3'd0, 1'b0, -1);
    ready_want = 1'b0;
    repeat (8) step();
    n_checks++;
    if (words_driven - d0 != 4 || ren_seen !== 1'b0 || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_stall got words=%0d ren=%b valid=%b want 4/0/1", words_driven - d0,
               ren_seen, out_valid);
    end
    ready_want = 1'b1;
    drain("bp");
    n_checks++;
    if (pop_cnt - p0 != 10 || rx_byte_cnt - b0 !== 32'd80) begin
      n_errors++;
      $display("FAIL bp_release got words=%0d bytes=%0d want 10/80", pop_cnt - p0,
               rx_byte_cnt - b0);
    end
    check_stats("bp");
  endtask

  task automatic test_back_to_back();
    int p0 = pop_cnt;
    logic [31:0] k0 = rx_pkt_cnt;
    ren_cnt = 0;
    add_frame(2, 3'd1, 1'b0, -1);
    add_frame(2, 3'd7, 1'b0, -1);
    drain("b2b");
    n_checks++;
    if (pop_cnt - p0 != 4 || rx_pkt_cnt - k0 !== 32'd2 || ren_cnt != 4) begin
      n_errors++;
      $display("FAIL b2b got words=%0d pkts=%0d ren=%0d want 4/2/4", pop_cnt - p0,
               rx_pkt_cnt - k0, ren_cnt);
    end
    check_stats("b2b");
  endtask

  task automatic test_error_frame();
    int pc0 = proto_cnt;
    add_frame(2, 3'd0, 1'b1, -1);
    drain("errf");
    n_checks++;
    if (rx_err_cnt !== 16'd1 || proto_cnt != pc0) begin
      n_errors++;
      $display("FAIL errf got err_cnt=%0d proto=%0d want 1/0", rx_err_cnt, proto_cnt - pc0);
    end
    check_stats("errf");
  endtask

  task automatic test_proto_stray();
    int pc0 = proto_cnt;
    logic [15:0] e0 = rx_err_cnt;
    en_want = 1'b0;
    add_frame(1, 3'd3, 1'b0, -1);
    mac_q[0].xerr = 1'b1;
    inject = 1'b1;
    drain("stray");
    n_checks++;
    if (proto_cnt - pc0 != 1 || rx_err_cnt !== e0 + 16'd1) begin
      n_errors++;
      $display("FAIL stray got proto=%0d err_cnt=%0d want 1/%0d", proto_cnt - pc0, rx_err_cnt,
               e0 + 16'd1);
    end
    check_stats("stray");
  endtask

  task automatic test_proto_sop();
    int pc0 = proto_cnt;
    logic [15:0] e0 = rx_err_cnt;
    en_want = 1'b1;
    add_frame(3, 3'd2, 1'b0, 1);
    drain("sopmid");
    n_checks++;
    if (proto_cnt - pc0 != 1 || rx_err_cnt !== e0) begin
      n_errors++;
      $display("FAIL sopmid got proto=%0d err_cnt=%0d want 1/%0d", proto_cnt - pc0, rx_err_cnt,
               e0);
    end
    check_stats("sopmid");
  endtask

  task automatic test_enable_reset();
    int p0 = pop_cnt;
    add_frame(5, 3'd4, 1'b0, -1);
    repeat (3) step();
    en_want = 1'b0;
    drain("en");
    n_checks++;
    if (pop_cnt - p0 != 5) begin
      n_errors++; $display("FAIL en_complete got %0d want 5", pop_cnt - p0);
    end
    check_stats("en");
    avail_hold = 1'b1; ren_cnt = 0;
    repeat (6) step();
    n_checks++;
    if (ren_cnt != 0) begin
      n_errors++; $display("FAIL en_off_ren got %0d want 0", ren_cnt);
    end
    avail_hold = 1'b0;
    en_want = 1'b1; ready_want = 1'b0;
    add_frame(6, 3'd0, 1'b0, -1);
    repeat (5) step();
    rst_want = 1'b0;
    mac_q.delete(); sb.delete();
    step();
    n_checks++;
    if (pkt_rx_ren !== 1'b0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_during got ren=%b valid=%b want 0/0", pkt_rx_ren, out_valid);
    end
    rst_want = 1'b1; en_want = 1'b0; ready_want = 1'b1;
    exp_pkt = 32'd0; exp_bytes = 32'd0; exp_err = 16'd0;
    step();
    n_checks++;
    if ({pkt_rx_ren, out_valid, out_sop, out_eop, out_err, proto_err} !== 6'd0 ||
        out_data !== 64'd0 || out_mod !== 3'd0) begin
      n_errors++;
      $display("FAIL rst_mid_outputs got ren=%b valid=%b data=%h want 0", pkt_rx_ren,
               out_valid, out_data);
    end
    check_stats("rst_mid");
  endtask

  task automatic test_wrap_sat();
    en_want = 1'b1; ready_want = 1'b1;
    step();
    force dut.byte_cnt_q = 32'hFFFF_FFFC;
    force dut.err_cnt_q  = 16'hFFFF;
    #1;
    release dut.byte_cnt_q;
    release dut.err_cnt_q;
    exp_bytes = 32'hFFFF_FFFC; exp_err = 16'hFFFF;
    add_frame(1, 3'd0, 1'b1, -1);
    drain("wrap");
    n_checks++;
    if (rx_byte_cnt !== 32'h0000_0004 || rx_err_cnt !== 16'hFFFF || rx_pkt_cnt !== 32'd1) begin
      n_errors++;
      $display("FAIL wrap_sat got bytes=%h err=%h pkts=%0d want 00000004/ffff/1", rx_byte_cnt,
               rx_err_cnt, rx_pkt_cnt);
    end
    check_stats("wrap");
  endtask

  initial begin
    test_reset();
    test_frame_read();
    test_backpressure();
    test_back_to_back();
    test_error_frame();
    test_proto_stray();
    test_proto_sop();
    test_enable_reset();
    test_wrap_sat();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
